regfile_writeback: RTL and testbench

Write-side controller for the 32×32 register file: merges single-cycle ALU results and multi-cycle load returns into the file's single write port (we3/a3/wd3). Sits between execute/memory stages and the register file. Buffers load returns in a small FIFO and keeps a per-register busy scoreboard for the decode stage's stall logic.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_fifo.sv | 63 ++++++
 rtl/regfile_writeback.sv | 110 +++++++++++
 tb/tb_regfile_writeback.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Purpose : Shared widths, register count and load-return entry type for the
//           register-file write-back controller.
// Revision: 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 never appears in the scoreboard, so its one-hot is all zeros
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    reg_onehot = '0;
    if (rd != '0) reg_onehot[rd] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Purpose : In-order synchronous FIFO of load-return entries with occupancy
//           count; pointers wrap modulo FIFO_DEPTH (power of two, >= 2).
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset: stale contents are unreachable once count is zero
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback
// Purpose : Arbitrates ALU results and buffered load returns onto the single
//           register-file write port; keeps the per-register load scoreboard.
//           Optional macro WB_BYPASS_EN lets a load skip an empty FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        ld_issue,
  input  logic [4:0]                  ld_issue_rd,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [4:0]                  ld_rd,
  input  logic [XLEN-1:0]             ld_data,
  output logic                        we3,
  output logic [4:0]                  a3,
  output logic [XLEN-1:0]             wd3,
  output logic [31:0]                 busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  // XLEN here must match wb_pkg::XLEN, which sizes the FIFO entries
  import wb_pkg::*;

  wb_entry_t             w_head;
  wb_entry_t             w_ld_entry;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_deq;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   r_busy;

  assign ld_ready   = !w_full;
  assign w_accept   = ld_valid && ld_ready;
  assign w_ld_entry = '{rd: ld_rd, data: ld_data};

`ifdef WB_BYPASS_EN
  assign w_bypass = w_accept && w_empty && !alu_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && !w_bypass;
  assign w_deq  = !w_empty && !alu_valid;

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_push),
    .push_entry (w_ld_entry),
    .pop        (w_deq),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .count      (fifo_count)
  );

  // ALU beats the FIFO head; bypass only fires when the FIFO is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (alu_valid) begin
      we3 <= (alu_rd != '0);
      a3  <= alu_rd;
      wd3 <= alu_data;
    end else if (w_deq) begin
      we3 <= (w_head.rd != '0);
      a3  <= w_head.rd;
      wd3 <= w_head.data;
    end else if (w_bypass) begin
      we3 <= (ld_rd != '0);
      a3  <= ld_rd;
      wd3 <= ld_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  assign w_set = ld_issue ? reg_onehot(ld_issue_rd) : '0;
  assign w_clr = w_deq    ? reg_onehot(w_head.rd)
               : w_bypass ? reg_onehot(ld_rd)
               : '0;

  // Set is applied after clear so a same-cycle reissue keeps the bit high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_clr) | w_set;
  end

  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_writeback
// Purpose : Directed, table-driven self-checking bench for regfile_writeback.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef WB_BYPASS_EN
  localparam int LD_LAT = 1;
`else
  localparam int LD_LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     busy;
  logic [CW-1:0]   fifo_count;

  regfile_writeback #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .we3         (we3),
    .a3          (a3),
    .wd3         (wd3),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        alu_valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_we3;
    logic        chk_addr;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd3;
  } alu_vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  ent_t ld_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  // One clock; the write seen after the edge is checked against the model
  task automatic step();
    logic        pv_alu;
    logic [4:0]  pv_rd;
    logic [31:0] pv_data;
    ent_t        e;
    pv_alu  = alu_valid;
    pv_rd   = alu_rd;
    pv_data = alu_data;
    if (ld_valid && ld_ready && ld_rd != 5'd0) ld_q.push_back({ld_rd, ld_data});
    @(posedge clk); #1;
    if (pv_alu) begin
      check("alu_we3", {63'd0, we3}, {63'd0, pv_rd != 5'd0});
      if (pv_rd != 5'd0) check("alu_write", {27'd0, a3, wd3}, {27'd0, pv_rd, pv_data});
    end else if (we3) begin
      if (ld_q.size() == 0) begin
        n_total++;
        $display("FAIL ld_unexpected: got write a3=%0d wd3=0x%0h, expected no write", a3, wd3);
      end else begin
        e = ld_q.pop_front();
        check("ld_order", {27'd0, a3, wd3}, {27'd0, e});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    alu_vec_t vecs[6];
    int       lat;
    int       k;
    int       n;
    logic     acc;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'hCAFE0000, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 1'b1, 5'd31, 32'h00000001};
    vecs[4] = '{1'b1, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b1, 5'd1,  32'hFFFFFFFF};
    vecs[5] = '{1'b0, 5'd9,  32'h12345678, 1'b0, 1'b0, 5'd0,  32'h0};

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we3",   {63'd0, we3},      64'd0);
    check("rst_a3",    {59'd0, a3},       64'd0);
    check("rst_wd3",   {32'd0, wd3},      64'd0);
    check("rst_busy",  {32'd0, busy},     64'd0);
    check("rst_count", {61'd0, fifo_count}, 64'd0);
    check("rst_ready", {63'd0, ld_ready}, 64'd1);
    rst_n = 1'b1;

    // ALU-only vectors
    for (int i = 0; i < 6; i++) begin
      alu_valid = vecs[i].alu_valid;
      alu_rd    = vecs[i].rd;
      alu_data  = vecs[i].data;
      step();
      check("vec_we3", {63'd0, we3}, {63'd0, vecs[i].exp_we3});
      if (vecs[i].chk_addr) begin
        check("vec_a3",  {59'd0, a3},  {59'd0, vecs[i].exp_a3});
        check("vec_wd3", {32'd0, wd3}, {32'd0, vecs[i].exp_wd3});
      end
    end
    clear_inputs();

    // Single load: issue, return, write-back latency and busy clear
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    step();
    ld_issue = 1'b0;
    check("ld_busy_set", {32'd0, busy}, 64'h80);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
    step();
    ld_valid = 1'b0;
`ifndef WB_BYPASS_EN
    check("ld_in_fifo", {61'd0, fifo_count}, 64'd1);
`endif
    lat = 1;
    while (!we3 && lat < 5) begin step(); lat++; end
    check("ld_latency",  lat,                 LD_LAT);
    check("ld_a3",       {59'd0, a3},         64'd7);
    check("ld_wd3",      {32'd0, wd3},        64'h1234);
    check("ld_busy_clr", {32'd0, busy},       64'd0);
    check("ld_count0",   {61'd0, fifo_count}, 64'd0);

    // Contention: six ALU cycles while five loads try to return
    k = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'hA000 + 32'(i);
      ld_valid  = (k < 5); ld_rd = 5'(10 + k); ld_data = 32'h100 + 32'(k);
      acc = ld_valid && ld_ready;
      step();
      if (acc) k++;
    end
    check("cont_accepts", k, 4);
    check("cont_ready0",  {63'd0, ld_ready},   64'd0);
    check("cont_full",    {61'd0, fifo_count}, 64'd4);
    alu_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ld_valid = (k < 5); ld_rd = 5'(10 + k); ld_data = 32'h100 + 32'(k);
      acc = ld_valid && ld_ready;
      step();
      if (acc) k++;
      check("drain_we3", {63'd0, we3}, 64'd1);
      check("drain_a3",  {59'd0, a3},  64'(10 + j));
    end
    ld_valid = 1'b0;
    for (int c = 0; c < 8 && (ld_q.size() != 0 || fifo_count != '0); c++) step();
    check("cont_all_acc", k, 5);
    check("cont_drained", ld_q.size(), 0);
    clear_inputs();
    step();

    // Scoreboard race: reissue rd 9 while the older rd 9 load retires
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
    ld_issue = 1'b0;
    check("race_set", {63'd0, busy[9]}, 64'd1);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
`ifdef WB_BYPASS_EN
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
`else
    step();
    ld_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    step();
`endif
    clear_inputs();
    check("race_write", {58'd0, we3, a3}, {58'd0, 1'b1, 5'd9});
    check("race_keep",  {63'd0, busy[9]}, 64'd1);
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h9A;
    step();
    ld_valid = 1'b0;
    for (int c = 0; c < 4 && !we3; c++) step();
    check("race_clear", {63'd0, busy[9]}, 64'd0);

    // Wrap-around: 3*FIFO_DEPTH loads with random ALU bubbles
    n = 0;
    for (int c = 0; c < 300 && !(n == 3*FIFO_DEPTH && fifo_count == '0 && ld_q.size() == 0); c++) begin
      alu_valid = (n < 3*FIFO_DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_rd    = 5'($urandom_range(1, 31));
      alu_data  = $urandom;
      ld_valid  = (n < 3*FIFO_DEPTH);
      ld_rd     = (n == 5) ? 5'd0 : 5'(1 + n);
      ld_data   = 32'h5000 + 32'(n);
      acc = ld_valid && ld_ready;
      step();
      if (acc) n++;
    end
    clear_inputs();
    check("wrap_accepts", n, 3*FIFO_DEPTH);
    check("wrap_no_loss", ld_q.size(), 0);
    check("wrap_count0",  {61'd0, fifo_count}, 64'd0);

    // Reset in the middle of traffic
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    ld_issue = 1'b1; ld_issue_rd = 5'd20;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h2020;
    step();
    step();
    check("pre_rst_count", {61'd0, fifo_count}, 64'd2);
    check("pre_rst_busy",  {63'd0, busy[20]},   64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we3",   {63'd0, we3},        64'd0);
    check("mid_rst_busy",  {32'd0, busy},       64'd0);
    check("mid_rst_count", {61'd0, fifo_count}, 64'd0);
    check("mid_rst_ready", {63'd0, ld_ready},   64'd1);
    clear_inputs();
    ld_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("post_rst_we3",   {63'd0, we3},        64'd0);
    check("post_rst_count", {61'd0, fifo_count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
